// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the mem_if memory-side responder.
package mem_if_pkg;

  localparam int MEM_DATA_W  = 8;
  localparam int MEM_TIMEOUT = 15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_if_wdog.sv
// Ack watchdog: down-counter reloaded by clr, terminal count after TIMEOUT enabled cycles.
module mem_if_wdog
  import mem_if_pkg::*;
#(
  parameter int TIMEOUT = MEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = LOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the TIMEOUT-th consecutive enabled cycle.
  assign tc = en && (cnt_q == '0);

endmodule

// File: rtl/mem_if.sv
// MAR/MBR owner turning control-unit strobes into RAM req/ack transactions.
// Optional ack watchdog and ERR state when MEM_IF_TIMEOUT_EN is defined.
module mem_if
  import mem_if_pkg::*;
#(
  parameter int DATA_W  = MEM_DATA_W,
  parameter int TIMEOUT = MEM_TIMEOUT
) (
  input  logic              mem_clk,
  input  logic              mem_rst_n,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] acc_in,
  input  logic              mar_we,
  input  logic              mar_sel,
  input  logic              mbr_ld,
  input  logic              mbr_we,
  input  logic              ram_we,
  output logic [DATA_W-1:0] mbr_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_req,
  output logic              ram_wr,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack
);

  // state | meaning
  // IDLE  | sample strobes, load MAR/MBR, launch RD or WR
  // RD    | request read at MAR, capture ram_rdata on ack
  // WR    | request write of MBR to MAR
  // DONE  | one-cycle completion pulse, still busy
  // ERR   | watchdog abort (timeout builds only)

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mbr_q, mbr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;

`ifdef MEM_IF_TIMEOUT_EN
  logic err_q, err_d;
  logic wdog_tc;
  logic in_xfer;

  assign in_xfer = (state_q == S_RD) || (state_q == S_WR);

  mem_if_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk   (mem_clk),
    .rst_n (mem_rst_n),
    .clr   (!in_xfer),
    .en    (in_xfer),
    .tc    (wdog_tc)
  );
`endif

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mbr_d   = mbr_q;
`ifdef MEM_IF_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (mar_we) mar_d = mar_sel ? acc_in : pc_in;
        if (mbr_ld) mbr_d = acc_in;
        // A write beats a simultaneous read; the read is dropped.
        if (ram_we) begin
          state_d = S_WR;
        end else if (mbr_we) begin
          state_d = S_RD;
        end
`ifdef MEM_IF_TIMEOUT_EN
        if (ram_we || mbr_we) err_d = 1'b0;
`endif
      end
      S_RD: begin
        if (ram_ack) begin
          mbr_d   = ram_rdata;
          state_d = S_DONE;
        end
`ifdef MEM_IF_TIMEOUT_EN
        else if (wdog_tc) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
`endif
      end
      S_WR: begin
        if (ram_ack) begin
          state_d = S_DONE;
        end
`ifdef MEM_IF_TIMEOUT_EN
        else if (wdog_tc) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
`endif
      end
      S_ERR:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs decoded from next state so they come straight off flops.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    req_d  = (state_d == S_RD) || (state_d == S_WR);
    wr_d   = (state_d == S_WR);
  end

  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state_q <= S_IDLE;
      mar_q   <= '0;
      mbr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
`ifdef MEM_IF_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mbr_q   <= mbr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
`ifdef MEM_IF_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign mbr_out   = mbr_q;
  assign ram_addr  = mar_q;
  assign ram_wdata = mbr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_req   = req_q;
  assign ram_wr    = wr_q;
`ifdef MEM_IF_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule
